// File: rtl/qx1_pkg.sv
// Shared types and constants for the qx1 front end.
// Instruction and address words are both XLEN bits; PCs are always even.
package qx1_pkg;

  localparam int XLEN = 16;

  typedef logic [XLEN-1:0] instr_t;
  typedef logic [XLEN-1:0] addr_t;

  localparam addr_t PC_STEP = addr_t'(2);

  typedef struct packed {
    instr_t instr;
    addr_t  pc;
  } entry_t;

  // Instructions are halfword aligned, so bit 0 of any target is dropped.
  function automatic addr_t align_pc(addr_t a);
    return a & ~(addr_t'(1));
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: fetch control, instruction-memory port and decode handshake.
// master is the fetch stage, slave is the memory/decode side.
interface fetch_stage_if;
  import qx1_pkg::*;

  logic   fetch_en;
  logic   redirect_valid;
  addr_t  redirect_pc;
  addr_t  pc;
  instr_t instruction;
  logic   out_valid;
  logic   out_ready;
  instr_t out_instr;
  addr_t  out_pc;

  modport master (
    input  fetch_en,
    input  redirect_valid,
    input  redirect_pc,
    output pc,
    input  instruction,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    output fetch_en,
    output redirect_valid,
    output redirect_pc,
    input  pc,
    output instruction,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );

endinterface

// File: rtl/fetch_buffer.sv
// Two-entry instruction FIFO with a fixed head slot so the head outputs come
// straight from flops. Push and pop may happen together even when full.
module fetch_buffer
  import qx1_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       flush,
  input  instr_t     push_instr,
  input  addr_t      push_pc,
  output logic [1:0] count,
  output logic       head_valid,
  output instr_t     head_instr,
  output addr_t      head_pc
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  entry_t head;
  entry_t tail;
  entry_t incoming;
  logic   do_pop;
  logic   do_push;

  assign incoming = '{instr: push_instr, pc: push_pc};

  // Guards make underflow and overflow impossible regardless of the caller.
  assign do_pop  = pop && (count != 2'd0) && !flush;
  assign do_push = push && !flush && ((count != FULL) || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Data slots carry no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      if (do_push && (count == 2'd1)) head <= incoming;
      else                            head <= tail;
    end else if (do_push && (count == 2'd0)) begin
      head <= incoming;
    end

    if (do_push && (((count == 2'd1) && !do_pop) || ((count == FULL) && do_pop))) begin
      tail <= incoming;
    end
  end

  assign head_valid = (count != 2'd0);
  assign head_instr = head.instr;
  assign head_pc    = head.pc;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, decides push/pop/flush and feeds fetch_buffer.
// A redirect flushes the buffer and retargets the PC; no fetch happens that cycle.
module fetch_stage
  import qx1_pkg::*;
#(
  parameter addr_t RESET_PC = 16'h0000,
  parameter int    DEPTH    = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_stage_if.master bus
);

  localparam logic [1:0] FULL = 2'(DEPTH);

  addr_t      pc_q;
  logic [1:0] count;
  logic       head_valid;
  instr_t     head_instr;
  addr_t      head_pc;
  logic       push;
  logic       pop;
  logic       flush;

  assign flush = bus.redirect_valid && !rst;
  assign pop   = head_valid && bus.out_ready && !bus.redirect_valid && !rst;
  assign push  = bus.fetch_en && !bus.redirect_valid && !rst
               && ((count != FULL) || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= align_pc(RESET_PC);
    end else if (bus.redirect_valid) begin
      pc_q <= align_pc(bus.redirect_pc);
    end else if (push) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .push_instr (bus.instruction),
    .push_pc    (pc_q),
    .count      (count),
    .head_valid (head_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

  assign bus.pc        = pc_q;
  assign bus.out_valid = head_valid;
  assign bus.out_instr = head_instr;
  assign bus.out_pc    = head_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, scored
// against a queue-based model of the fetch rules.
module tb_fetch_stage;

  logic clk;
  logic rst;

  fetch_stage_if bus();
  fetch_stage_if bus_w();

  fetch_stage #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  fetch_stage #(.RESET_PC(16'hFFFC), .DEPTH(2)) dut_w (
    .clk (clk),
    .rst (rst),
    .bus (bus_w)
  );

  typedef struct {
    int pc;
    int instr;
  } exp_t;

  int   total;
  int   bad;
  exp_t exp_q[$];
  int   m_pc;
  int   m_cnt;

  // memory word[k] = 16'h1000 + k, k = byte address / 2
  function automatic logic [15:0] mem_word(input int a);
    return 16'((32'h1000 + (a / 2)) & 32'hFFFF);
  endfunction

  assign bus.instruction   = mem_word(int'(bus.pc));
  assign bus_w.instruction = mem_word(int'(bus_w.pc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: check state left by the previous edge, drive inputs, advance model.
  task automatic step(input bit fe, input bit rv, input int rpc, input bit ordy, input bit r);
    bit pop_m;
    bit push_m;
    @(negedge clk);
    chk("pc", bus.pc, m_pc);
    chk("out_valid", bus.out_valid, (m_cnt != 0));
    rst                = r;
    bus.fetch_en       = fe;
    bus.redirect_valid = rv;
    bus.redirect_pc    = 16'(rpc);
    bus.out_ready      = ordy;
    if (r) begin
      m_pc  = 0;
      m_cnt = 0;
      exp_q.delete();
    end else if (rv) begin
      m_pc  = (rpc % 65536) / 2 * 2;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      pop_m  = (m_cnt > 0) && ordy;
      push_m = fe && ((m_cnt < 2) || pop_m);
      m_cnt  = m_cnt + int'(push_m) - int'(pop_m);
      if (push_m) begin
        exp_q.push_back('{pc: m_pc, instr: int'(mem_word(m_pc))});
        m_pc = (m_pc + 2) % 65536;
      end
    end
  endtask

  // Monitor: every accepted head must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (bus.out_valid && bus.out_ready && !bus.redirect_valid && !rst) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected got_pc=%h want=none", bus.out_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", bus.out_pc, e.pc);
          chk("sb_instr", bus.out_instr, e.instr);
        end
      end
    end
  end

  initial begin
    logic [15:0] seq_w [4];
    seq_w[0] = 16'hFFFC;
    seq_w[1] = 16'hFFFE;
    seq_w[2] = 16'h0000;
    seq_w[3] = 16'h0002;
    total = 0;
    bad   = 0;
    m_pc  = 0;
    m_cnt = 0;
    rst                  = 1'b1;
    bus.fetch_en         = 1'b0;
    bus.redirect_valid   = 1'b0;
    bus.redirect_pc      = 16'h0;
    bus.out_ready        = 1'b0;
    bus_w.fetch_en       = 1'b1;
    bus_w.redirect_valid = 1'b0;
    bus_w.redirect_pc    = 16'h0;
    bus_w.out_ready      = 1'b1;

    // reset, then straight-line fetch with decode always ready
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0);
    chk("rst_pc_wrap", bus_w.pc, 16'hFFFC);
    chk("rst_valid_wrap", bus_w.out_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0, 1, 0);
      chk("seq_pc", bus.out_pc, 2 * k);
      chk("seq_instr", bus.out_instr, 32'h1000 + k);
      chk("wrap_pc", bus_w.out_pc, seq_w[k]);
    end

    // decode stalls five cycles with the buffer full
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int k = 0; k < 7; k++) step(1, 0, 0, 0, 0);
    chk("stall_pc", bus.pc, 16'h0004);
    chk("stall_head", bus.out_pc, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 1, 0);
      chk("release_pc", bus.out_pc, 2 * k);
    end

    // redirect to an odd target while full
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 1, 'h31, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("redir_valid", bus.out_valid, 1'b0);
    chk("redir_pc", bus.pc, 16'h0030);
    step(1, 0, 0, 1, 0);
    chk("redir_head_valid", bus.out_valid, 1'b1);
    chk("redir_head_pc", bus.out_pc, 16'h0030);
    chk("redir_head_instr", bus.out_instr, 16'h1018);

    // one-cycle reset while full
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    chk("midrst_valid", bus.out_valid, 1'b0);
    chk("midrst_pc", bus.pc, 16'h0000);
    step(1, 0, 0, 0, 0);
    chk("midrst_head", bus.out_pc, 16'h0000);

    // fetch disabled: buffer drains by exactly two, pc holds
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("drain_head", bus.out_pc, 16'h0002);
    step(0, 0, 0, 1, 0);
    chk("drain_empty", bus.out_valid, 1'b0);
    chk("drain_pc", bus.pc, 16'h0004);
    step(0, 1, 'h100, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("drain_redir_pc", bus.pc, 16'h0100);

    // random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 4) != 0, ($urandom % 10) == 0, int'($urandom_range(0, 65535)),
           ($urandom % 3) != 0, ($urandom % 60) == 0);
    end

    // drain and confirm every expected entry was delivered
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
